// File: rtl/ps2_key_tracker_pkg.sv
// Shared types and constants for the PS/2 scan-code set 2 key tracker.
package ps2_pkg;

    localparam int unsigned KEY_W    = 9;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned SKIP_W   = 3;
    localparam int unsigned SKIP_LEN = 7;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_BAT        = 8'hAA;
    localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;
    localparam logic [7:0] PS2_NUL        = 8'h00;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_ERR        = 8'hFF;
    localparam logic [7:0] PS2_ECHO       = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_t;

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte-stream input and key-state/event output bundle of the key tracker.
interface ps2_key_tracker_if
    import ps2_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
);
    logic [7:0]                 byte_in;
    logic                       byte_valid;
    logic                       clear_ovf;
    logic [NUM_SLOTS*KEY_W-1:0] keys_out;
    logic [NUM_SLOTS-1:0]       key_valid;
    logic [CNT_W-1:0]           key_count;
    logic                       evt_valid;
    key_t                       evt_key;
    logic                       evt_make;
    logic                       ovf;

    modport master (
        output byte_in, byte_valid, clear_ovf,
        input  keys_out, key_valid, key_count, evt_valid, evt_key, evt_make, ovf
    );

    modport slave (
        input  byte_in, byte_valid, clear_ovf,
        output keys_out, key_valid, key_count, evt_valid, evt_key, evt_make, ovf
    );
endinterface

// File: rtl/ps2_slot_file.sv
// Ordered, compacted list of held keys with lookup/append/delete/clear and a sticky overflow flag.
module ps2_slot_file
    import ps2_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       make,
    input  logic                       brk,
    input  logic                       clr,
    input  logic                       clear_ovf,
    input  key_t                       key,
    output logic                       make_ok_c,
    output logic                       brk_ok_c,
    output logic [NUM_SLOTS*KEY_W-1:0] keys_out,
    output logic [NUM_SLOTS-1:0]       key_valid,
    output logic [CNT_W-1:0]           key_count,
    output logic                       ovf
);

    key_t                 slots_q   [NUM_SLOTS];
    key_t                 slots_d   [NUM_SLOTS];
    key_t                 slots_ext [NUM_SLOTS+1];
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [NUM_SLOTS:0]   valid_ext;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 hit;
    logic [CNT_W-1:0]     hit_idx;

    // Next-state: one operation per cycle; a set of ovf wins over clear_ovf
    always_comb begin
        slots_d   = slots_q;
        valid_d   = valid_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        make_ok_c = 1'b0;
        brk_ok_c  = 1'b0;
        hit       = 1'b0;
        hit_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slots_ext[i] = slots_q[i];
        end
        slots_ext[NUM_SLOTS] = '0;
        valid_ext            = {1'b0, valid_q};

        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!hit && valid_q[i] && (slots_q[i] == key)) begin
                hit     = 1'b1;
                hit_idx = CNT_W'(i);
            end
        end

        if (clear_ovf) begin
            ovf_d = 1'b0;
        end

        if (clr) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slots_d[i] = '0;
            end
            valid_d = '0;
            count_d = '0;
        end else if (make && !hit) begin
            if (count_q < CNT_W'(NUM_SLOTS)) begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (CNT_W'(i) == count_q) begin
                        slots_d[i] = key;
                        valid_d[i] = 1'b1;
                    end
                end
                count_d   = count_q + CNT_W'(1);
                make_ok_c = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (brk && hit) begin
            // Close the gap: everything above the released key moves down one slot
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (CNT_W'(i) >= hit_idx) begin
                    slots_d[i] = slots_ext[i+1];
                    valid_d[i] = valid_ext[i+1];
                end
            end
            count_d  = count_q - CNT_W'(1);
            brk_ok_c = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            slots_q <= slots_d;
            valid_q <= valid_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        keys_out = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            keys_out[i*KEY_W +: KEY_W] = slots_q[i];
        end
    end

    assign key_valid = valid_q;
    assign key_count = count_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Scan-code set 2 parser feeding a held-key slot file; emits registered make/break events.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input logic               Clk,
    input logic               Reset_n,
    ps2_key_tracker_if.slave  bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    ps2_state_e        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              make_c, brk_c, clr_c;
    key_t              key_c;
    logic              make_ok_c, brk_ok_c;
    logic              evt_valid_q, evt_make_q;
    key_t              evt_key_q;

    // Parser next-state, idle timeout and slot-file commands
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        skip_d  = skip_q;
        make_c  = 1'b0;
        brk_c   = 1'b0;
        clr_c   = 1'b0;
        key_c   = '{ext: 1'b0, code: bus.byte_in};

        if (bus.byte_valid) begin
            tmr_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    case (bus.byte_in)
                        PS2_EXT:   state_d = ST_EXT;
                        PS2_BRK:   state_d = ST_BRK;
                        PS2_PAUSE: begin
                            state_d = ST_SKIP;
                            skip_d  = SKIP_W'(SKIP_LEN);
                        end
                        PS2_BAT:   clr_c = 1'b1;
                        PS2_NUL, PS2_ACK, PS2_RESEND, PS2_ERR, PS2_ECHO: begin
                        end
                        default:   make_c = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    key_c.ext = 1'b1;
                    if (bus.byte_in == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        make_c  = (bus.byte_in != PS2_FAKE_SHIFT);
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_c   = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    key_c.ext = 1'b1;
                    brk_c     = (bus.byte_in != PS2_FAKE_SHIFT);
                    state_d   = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled prefix is abandoned so a lost byte cannot corrupt the next code
            if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            skip_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_make_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            skip_q      <= skip_d;
            evt_valid_q <= make_ok_c | brk_ok_c;
            if (make_ok_c || brk_ok_c) begin
                evt_key_q  <= key_c;
                evt_make_q <= make_ok_c;
            end
        end
    end

    ps2_slot_file #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slots (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .make      (make_c),
        .brk       (brk_c),
        .clr       (clr_c),
        .clear_ovf (bus.clear_ovf),
        .key       (key_c),
        .make_ok_c (make_ok_c),
        .brk_ok_c  (brk_ok_c),
        .keys_out  (bus.keys_out),
        .key_valid (bus.key_valid),
        .key_count (bus.key_count),
        .ovf       (bus.ovf)
    );

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_key   = evt_key_q;
    assign bus.evt_make  = evt_make_q;

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 key-state tracker sitting between the PS/2 byte receiver (`keyboard`) and the game logic; it generalises the fixed four-slot `PS2reg`. It parses the scan-code set 2 byte stream (make, `F0` break, `E0` extended, `E1` pause sequences, `AA` self-test), keeps an ordered, compacted list of up to NUM_SLOTS currently held keys, and emits per-key make/break events. Its outputs feed `game_logic` and the hex/LED debug displays in `project`.

## Interface
- NUM_SLOTS, 4: maximum simultaneously held keys tracked (1..16).
- TIMEOUT_CYC, 100000: idle cycles after which a partial prefix is discarded (2 ms at 50 MHz).
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- byte_in  in  8  received scan-code byte from the PS/2 receiver.
- byte_valid  in  1  one-cycle strobe; byte_in is valid this cycle.
- clear_ovf  in  1  one-cycle strobe; clears ovf.
- keys_out  out  NUM_SLOTS*9  packed slots; slot i = bits [9i+8:9i] = {ext, code}; slot 0 is the oldest held key.
- key_valid  out  NUM_SLOTS  bit i set when slot i holds a key; always a contiguous run from bit 0.
- key_count  out  5  number of held keys.
- evt_valid  out  1  one-cycle strobe on each accepted make or break.
- evt_key  out  9  {ext, code} of the event.
- evt_make  out  1  1 = make, 0 = break.
- ovf  out  1  sticky; a make arrived while all slots were full.

## Operation
- Parser FSM states: IDLE, EXT (after `E0`), BRK (after `F0`), EXT_BRK (after `E0 F0`), SKIP (inside `E1` sequence).
- IDLE: `E0`→EXT; `F0`→BRK; `E1`→SKIP with skip counter = 7; `AA`→clear all slots, stay IDLE, no event; `00`, `FA`, `FE`, `FF`, `EE` ignored; other byte → make of {0, byte}.
- EXT: `F0`→EXT_BRK; `12` (fake shift) is dropped →IDLE; other → make of {1, byte}, →IDLE.
- BRK: any byte → break of {0, byte}, →IDLE. EXT_BRK: `12` dropped; other → break of {1, byte}, →IDLE.
- SKIP: each byte decrements the counter; at 0 → IDLE. Pause produces no event and no slot.
- Make: if the key is already held (typematic repeat) → no slot change, no event. Otherwise, if key_count < NUM_SLOTS, write to slot key_count and emit an event; if full, drop the key, set ovf, and emit no event.
- Break: if the key is held in slot i → slots i+1..top shift down one, the top slot is cleared, key_count decrements, and an event is emitted. A break for a key not held is ignored with no event.
- Timeout: in any state other than IDLE, if no byte_valid arrives for TIMEOUT_CYC cycles → IDLE. The timer restarts on every byte.
- ovf: set has priority over a clear_ovf in the same cycle.

## Timing
- All outputs are registered. Reset values: keys_out = 0, key_valid = 0, key_count = 0, evt_* = 0, ovf = 0, FSM = IDLE, timer and skip counter = 0.
- Latency: slot, count, and event outputs update on the edge after the byte_valid cycle that completes a code. evt_valid is high for exactly 1 cycle.
- Prefix bytes produce no output change.
- byte_valid may arrive on consecutive cycles; every byte is processed in the cycle it arrives, with no backpressure.
- `AA` while slots are held: the next cycle has key_valid = 0 and key_count = 0, and no break events are emitted.
- Reset_n assertion mid-sequence immediately returns all state to reset values.

## Structure
- `ps2_pkg`: parser state enum; constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, PS2_PAUSE = 8'hE1, PS2_BAT = 8'hAA, PS2_FAKE_SHIFT = 8'h12; key type typedef (9 bits).
- Sub-module `ps2_slot_file`: holds the slot array with lookup, append, delete-with-compaction, and clear operations, plus the overflow flag. The parser FSM, timeout counter, and skip counter stay in the top module.

## Test plan
- Bytes `1D`, `F0 1D` → after `1D`: slot0 = 0x01D, count = 1, make event; after the break: count = 0, key_valid = 0, break event {0x01D, make = 0}.
- Bytes `E0 75`, `1C`, `E0 F0 75` (NUM_SLOTS = 4) → slots fill 0x175 then 0x01C; after the break: slot0 = 0x01C, count = 1 (compaction), evt_key = 0x175.
- Five distinct makes `1C 1B 23 1D 29` with NUM_SLOTS = 4 → count = 4, 0x029 absent, ovf = 1, four events only; clear_ovf in the same cycle as a sixth make (`2B`) → ovf stays 1.
- `1D 1D 1D` (typematic repeat) → count = 1, exactly one evt_valid pulse.
- `E1 14 77 E1 F0 14 F0 77`, then `1C` → no events during the pause sequence; `1C` yields a make.
- `E0`, then 100000 idle cycles, then `1D` → make of 0x01D (not 0x11D). Separately, `AA` with 3 keys held → count = 0 on the next cycle.
